// File: rtl/tb_douta_map_if.sv
// rtl/tb_douta_map_if.sv - TB port A read / CB write-back / NL capture signal bundle
//
// Purpose : groups the temporary-buffer read request, read data and the
//           mapped covariance-buffer / non-linear capture results.
// Modports: master - issues reads and TB data, observes results (controller / bench)
//           slave  - the lane mapper (tb_douta_map)
// Signals : TB_douta_sel, TB_rd_en, l_k_0, seq_cnt_out, TB_douta  (master -> slave)
//           CB_dina, CB_wr_en, nl_z_1, nl_z_2, nl_valid            (slave -> master)

interface tb_douta_map_if #(
    parameter int L               = 4,
    parameter int RSA_DW          = 32,
    parameter int SEQ_CNT_DW      = 10,
    parameter int TB_DOUTA_SEL_DW = 5
);
    logic [TB_DOUTA_SEL_DW-1:0] TB_douta_sel;
    logic                       TB_rd_en;
    logic                       l_k_0;
    logic [SEQ_CNT_DW-1:0]      seq_cnt_out;
    logic [L*RSA_DW-1:0]        TB_douta;
    logic [L*RSA_DW-1:0]        CB_dina;
    logic                       CB_wr_en;
    logic [RSA_DW-1:0]          nl_z_1;
    logic [RSA_DW-1:0]          nl_z_2;
    logic                       nl_valid;

    modport master (
        output TB_douta_sel, TB_rd_en, l_k_0, seq_cnt_out, TB_douta,
        input  CB_dina, CB_wr_en, nl_z_1, nl_z_2, nl_valid
    );

    modport slave (
        input  TB_douta_sel, TB_rd_en, l_k_0, seq_cnt_out, TB_douta,
        output CB_dina, CB_wr_en, nl_z_1, nl_z_2, nl_valid
    );
endinterface

// File: rtl/tb_douta_map.sv
// rtl/tb_douta_map.sv - TB port A read-side lane mapper with NL_UPD capture
//
// Purpose : delays the read controls by RD_LAT so they line up with TB_douta,
//           maps TB lanes onto the CB write-back word (POS / NEG / NEW) and
//           captures the two innovation results (seq 1, seq 2) in NL_UPD mode.
// Ports   : clk     - system clock
//           sys_rst - asynchronous active-high reset
//           bus     - tb_douta_map_if.slave (read request in, CB / NL results out)
// Config  : TB_DOUTA_NEG_EN defined -> NEG direction reverses the first X lanes;
//           undefined -> NEG behaves as IDLE (no write, zero data).

module tb_douta_map #(
    parameter int X               = 4,
    parameter int L               = 4,
    parameter int RSA_DW          = 32,
    parameter int SEQ_CNT_DW      = 10,
    parameter int TB_DOUTA_SEL_DW = 5,
    parameter int RD_LAT          = 2
) (
    input  logic             clk,
    input  logic             sys_rst,
    tb_douta_map_if.slave    bus
);
    localparam int W = L * RSA_DW;

    localparam logic [2:0] MODE_CB  = 3'b100;
    localparam logic [2:0] MODE_NL  = 3'b111;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b10;
    localparam logic [1:0] DIR_NEW  = 2'b11;

    typedef enum logic {NL_IDLE, NL_HAVE1} nl_state_t;

    // Control delay line; index RD_LAT-1 is aligned with TB_douta.
    logic [TB_DOUTA_SEL_DW-1:0] r_sel_pipe [RD_LAT];
    logic [SEQ_CNT_DW-1:0]      r_seq_pipe [RD_LAT];
    logic                       r_lk_pipe  [RD_LAT];
    logic                       r_rd_pipe  [RD_LAT];

    nl_state_t                  r_nl_state;
    nl_state_t                  w_nl_next;

    logic [W-1:0]               r_cb_dina;
    logic                       r_cb_wr_en;
    logic [RSA_DW-1:0]          r_nl_z_1;
    logic [RSA_DW-1:0]          r_nl_z_2;
    logic                       r_nl_valid;

    logic [TB_DOUTA_SEL_DW-1:0] w_sel_d;
    logic [SEQ_CNT_DW-1:0]      w_seq_d;
    logic                       w_lk_d;
    logic                       w_rd_d;
    logic [2:0]                 w_mode;
    logic [1:0]                 w_dir;
    logic [W-1:0]               w_cb_dina;
    logic                       w_cb_wr_en;
    logic                       w_cap1;
    logic                       w_cap2;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_sel_pipe[i] <= '0;
                r_seq_pipe[i] <= '0;
                r_lk_pipe[i]  <= 1'b0;
                r_rd_pipe[i]  <= 1'b0;
            end
        end else begin
            r_sel_pipe[0] <= bus.TB_douta_sel;
            r_seq_pipe[0] <= bus.seq_cnt_out;
            r_lk_pipe[0]  <= bus.l_k_0;
            r_rd_pipe[0]  <= bus.TB_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                r_sel_pipe[i] <= r_sel_pipe[i-1];
                r_seq_pipe[i] <= r_seq_pipe[i-1];
                r_lk_pipe[i]  <= r_lk_pipe[i-1];
                r_rd_pipe[i]  <= r_rd_pipe[i-1];
            end
        end
    end

    assign w_sel_d = r_sel_pipe[RD_LAT-1];
    assign w_seq_d = r_seq_pipe[RD_LAT-1];
    assign w_lk_d  = r_lk_pipe[RD_LAT-1];
    assign w_rd_d  = r_rd_pipe[RD_LAT-1];
    assign w_mode  = w_sel_d[4:2];
    assign w_dir   = w_sel_d[1:0];

    // CB write-back lane mapping
    always_comb begin
        w_cb_dina  = '0;
        w_cb_wr_en = 1'b0;
        if (w_rd_d && (w_mode == MODE_CB)) begin
            case (w_dir)
                DIR_POS: begin
                    w_cb_dina  = bus.TB_douta;
                    w_cb_wr_en = 1'b1;
                end
`ifdef TB_DOUTA_NEG_EN
                DIR_NEG: begin
                    for (int i = 0; i < X; i++) begin
                        w_cb_dina[i*RSA_DW +: RSA_DW] = bus.TB_douta[(X-1-i)*RSA_DW +: RSA_DW];
                    end
                    w_cb_wr_en = 1'b1;
                end
`endif
                DIR_NEW: begin
                    // l_k_0 picks which half (lanes 0,1 or lanes 2,3) goes to CB lanes 0,1
                    if (w_lk_d) begin
                        w_cb_dina[0 +: 2*RSA_DW] = bus.TB_douta[0 +: 2*RSA_DW];
                    end else begin
                        w_cb_dina[0 +: 2*RSA_DW] = bus.TB_douta[2*RSA_DW +: 2*RSA_DW];
                    end
                    w_cb_wr_en = 1'b1;
                end
                default: begin
                    w_cb_dina  = '0;
                    w_cb_wr_en = 1'b0;
                end
            endcase
        end
    end

    // NL capture FSM: only real reads advance it; a read in any other mode breaks the pair
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_nl_state <= NL_IDLE;
        end else begin
            r_nl_state <= w_nl_next;
        end
    end

    always_comb begin
        w_nl_next = r_nl_state;
        w_cap1    = 1'b0;
        w_cap2    = 1'b0;
        if (w_rd_d) begin
            if (w_mode == MODE_NL) begin
                case (r_nl_state)
                    NL_IDLE: begin
                        if (w_seq_d == SEQ_CNT_DW'(1)) begin
                            w_cap1    = 1'b1;
                            w_nl_next = NL_HAVE1;
                        end
                    end
                    NL_HAVE1: begin
                        if (w_seq_d == SEQ_CNT_DW'(1)) begin
                            w_cap1    = 1'b1;
                        end else if (w_seq_d == SEQ_CNT_DW'(2)) begin
                            w_cap2    = 1'b1;
                            w_nl_next = NL_IDLE;
                        end
                    end
                    default: w_nl_next = NL_IDLE;
                endcase
            end else begin
                w_nl_next = NL_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cb_dina  <= '0;
            r_cb_wr_en <= 1'b0;
            r_nl_z_1   <= '0;
            r_nl_z_2   <= '0;
            r_nl_valid <= 1'b0;
        end else begin
            r_cb_dina  <= w_cb_dina;
            r_cb_wr_en <= w_cb_wr_en;
            r_nl_valid <= w_cap2;
            if (w_cap1) begin
                r_nl_z_1 <= bus.TB_douta[RSA_DW-1:0];
            end
            if (w_cap2) begin
                r_nl_z_2 <= bus.TB_douta[RSA_DW-1:0];
            end
        end
    end

    assign bus.CB_dina  = r_cb_dina;
    assign bus.CB_wr_en = r_cb_wr_en;
    assign bus.nl_z_1   = r_nl_z_1;
    assign bus.nl_z_2   = r_nl_z_2;
    assign bus.nl_valid = r_nl_valid;

endmodule

// File: tb/tb_tb_douta_map.sv
// tb/tb_tb_douta_map.sv - self-checking bench for tb_douta_map

module tb_tb_douta_map;
    localparam int X       = 4;
    localparam int L       = 4;
    localparam int DW      = 32;
    localparam int SDW     = 10;
    localparam int SELW    = 5;
    localparam int RD_LAT  = 2;
    localparam int W       = L * DW;
    localparam int MAXC    = 4096;

    localparam logic [4:0] S_POS  = 5'b10001;
    localparam logic [4:0] S_NEG  = 5'b10010;
    localparam logic [4:0] S_NEW  = 5'b10011;
    localparam logic [4:0] S_CBI  = 5'b10000;
    localparam logic [4:0] S_NL   = 5'b11100;

    logic clk;
    logic sys_rst;

    tb_douta_map_if #(.L(L), .RSA_DW(DW), .SEQ_CNT_DW(SDW), .TB_DOUTA_SEL_DW(SELW)) bus ();

    tb_douta_map #(
        .X(X), .L(L), .RSA_DW(DW), .SEQ_CNT_DW(SDW),
        .TB_DOUTA_SEL_DW(SELW), .RD_LAT(RD_LAT)
    ) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int eff_start = 0;

    // request history, indexed by issue cycle (the bench acts as the TB BRAM)
    logic [4:0]     h_sel  [MAXC];
    logic           h_rd   [MAXC];
    logic           h_lk   [MAXC];
    logic [SDW-1:0] h_seq  [MAXC];
    logic [W-1:0]   h_data [MAXC];

    // reference model state
    logic [W-1:0]   exp_dina;
    logic           exp_wr;
    logic           exp_valid;
    logic [DW-1:0]  m_z1;
    logic [DW-1:0]  m_z2;
    bit             m_have1;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    // Expected outputs for one completed read, from the lane rules.
    task automatic model_apply(input int j);
        logic [DW-1:0] tl [4];
        logic [DW-1:0] cl [4];
        logic [2:0] mode;
        logic [1:0] dir;
        int base;
        for (int i = 0; i < 4; i++) begin
            tl[i] = h_data[j][i*DW +: DW];
            cl[i] = '0;
        end
        mode = h_sel[j][4:2];
        dir  = h_sel[j][1:0];
        exp_wr    = 1'b0;
        exp_valid = 1'b0;
        if (mode == 3'b100) begin
            m_have1 = 0;
            if (dir == 2'd1) begin
                for (int i = 0; i < 4; i++) cl[i] = tl[i];
                exp_wr = 1'b1;
            end else if (dir == 2'd2) begin
`ifdef TB_DOUTA_NEG_EN
                for (int i = 0; i < X; i++) cl[i] = tl[X-1-i];
                exp_wr = 1'b1;
`endif
            end else if (dir == 2'd3) begin
                base = h_lk[j] ? 0 : 2;
                cl[0] = tl[base];
                cl[1] = tl[base+1];
                exp_wr = 1'b1;
            end
        end else if (mode == 3'b111) begin
            if (h_seq[j] == 1) begin
                m_z1 = tl[0];
                m_have1 = 1;
            end else if (h_seq[j] == 2 && m_have1) begin
                m_z2 = tl[0];
                exp_valid = 1'b1;
                m_have1 = 0;
            end
        end else begin
            m_have1 = 0;
        end
        exp_dina = {cl[3], cl[2], cl[1], cl[0]};
    endtask

    // One clock: issue request for cycle cyc, present BRAM data for cyc-RD_LAT,
    // then check the outputs belonging to request cyc-RD_LAT.
    task automatic step(input logic [4:0] sel, input logic rd, input logic lk,
                        input logic [SDW-1:0] seq, input logic [W-1:0] data);
        int j;
        h_sel[cyc] = sel; h_rd[cyc] = rd; h_lk[cyc] = lk; h_seq[cyc] = seq; h_data[cyc] = data;
        bus.TB_douta_sel = sel;
        bus.TB_rd_en     = rd;
        bus.l_k_0        = lk;
        bus.seq_cnt_out  = seq;
        if (cyc >= RD_LAT) bus.TB_douta = h_data[cyc-RD_LAT];
        else               bus.TB_douta = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        j = cyc - RD_LAT;
        if (j >= eff_start && j >= 0 && h_rd[j]) begin
            model_apply(j);
        end else begin
            exp_dina = '0; exp_wr = 1'b0; exp_valid = 1'b0;
        end
        check("cb_dina",  bus.CB_dina,        exp_dina);
        check("cb_wr_en", W'(bus.CB_wr_en),   W'(exp_wr));
        check("nl_valid", W'(bus.nl_valid),   W'(exp_valid));
        check("nl_z_1",   W'(bus.nl_z_1),     W'(m_z1));
        check("nl_z_2",   W'(bus.nl_z_2),     W'(m_z2));
        cyc++;
    endtask

    task automatic idle();
        step(S_NL, 1'b0, 1'b0, '0, {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic flush();
        for (int i = 0; i < RD_LAT; i++) idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dina"},  bus.CB_dina,      '0);
        check({tag, "_wr"},    W'(bus.CB_wr_en), '0);
        check({tag, "_valid"}, W'(bus.nl_valid), '0);
        check({tag, "_z1"},    W'(bus.nl_z_1),   '0);
        check({tag, "_z2"},    W'(bus.nl_z_2),   '0);
    endtask

    logic [W-1:0] rnd;
    logic [4:0]   rsel;
    logic         rrd;
    int           pick;
    int           pulses;

    initial begin
        m_z1 = '0; m_z2 = '0; m_have1 = 0;
        exp_dina = '0; exp_wr = 1'b0; exp_valid = 1'b0;
        sys_rst = 1'b1;
        bus.TB_douta_sel = S_NL; bus.TB_rd_en = 1'b0; bus.l_k_0 = 1'b0;
        bus.seq_cnt_out = '0; bus.TB_douta = '0;
        #22;
        check_all_zero("reset");
        @(negedge clk);
        sys_rst = 1'b0;

        // POS: outputs reflect the request RD_LAT+1 edges later
        step(S_POS, 1'b1, 1'b0, '0, 128'h00000004_00000003_00000002_00000001);
        flush();
        check("pos_word", bus.CB_dina, 128'h00000004_00000003_00000002_00000001);
        check("pos_wr",   W'(bus.CB_wr_en), W'(1));

        // NEG
        step(S_NEG, 1'b1, 1'b0, '0, 128'h00000044_00000033_00000022_00000011);
        flush();
`ifdef TB_DOUTA_NEG_EN
        check("neg_word", bus.CB_dina, 128'h00000011_00000022_00000033_00000044);
        check("neg_wr",   W'(bus.CB_wr_en), W'(1));
`else
        check("neg_word", bus.CB_dina, '0);
        check("neg_wr",   W'(bus.CB_wr_en), W'(0));
`endif

        // NEW, l_k_0 toggled back-to-back
        step(S_NEW, 1'b1, 1'b1, '0, 128'h0000000D_0000000C_0000000B_0000000A);
        step(S_NEW, 1'b1, 1'b0, '0, 128'h0000000D_0000000C_0000000B_0000000A);
        step(S_NEW, 1'b1, 1'b1, '0, 128'h0000000D_0000000C_0000000B_0000000A);
        check("new_lk1", bus.CB_dina, 128'h00000000_00000000_0000000B_0000000A);
        step(S_NEW, 1'b1, 1'b0, '0, 128'h0000000D_0000000C_0000000B_0000000A);
        check("new_lk0", bus.CB_dina, 128'h00000000_00000000_0000000D_0000000C);
        step(S_CBI, 1'b1, 1'b0, '0, 128'hFFFF);
        check("new_lk1b", bus.CB_dina, 128'h00000000_00000000_0000000B_0000000A);
        flush();
        check("cb_idle_wr", W'(bus.CB_wr_en), W'(0));

        // NL_UPD: seq 1 then seq 2 -> one pulse
        pulses = 0;
        step(S_NL, 1'b1, 1'b0, 10'd1, 128'h100);
        step(S_NL, 1'b1, 1'b0, 10'd2, 128'h200);
        pulses += bus.nl_valid;
        check("nl_no_wr1", W'(bus.CB_wr_en), W'(0));
        idle(); pulses += bus.nl_valid;
        idle(); pulses += bus.nl_valid;
        idle(); pulses += bus.nl_valid;
        check("nl_pulses", W'(pulses), W'(1));
        check("nl_z1_val", W'(bus.nl_z_1), W'(32'h100));
        check("nl_z2_val", W'(bus.nl_z_2), W'(32'h200));

        // seq 2 alone: no pulse
        step(S_NL, 1'b1, 1'b0, 10'd2, 128'h300);
        flush();
        check("seq2_alone", W'(bus.nl_valid), W'(0));
        check("seq2_z2",    W'(bus.nl_z_2), W'(32'h200));

        // seq 1, mode 100 read, seq 2: no pulse
        step(S_NL,  1'b1, 1'b0, 10'd1, 128'h400);
        step(S_POS, 1'b1, 1'b0, 10'd0, 128'h5);
        step(S_NL,  1'b1, 1'b0, 10'd2, 128'h600);
        idle();
        check("broken_run", W'(bus.nl_valid), W'(0));
        idle();
        check("broken_z1",  W'(bus.nl_z_1), W'(32'h400));

        // async reset with two reads in flight
        step(S_POS, 1'b1, 1'b0, '0, 128'hA1);
        step(S_POS, 1'b1, 1'b0, '0, 128'hA2);
        step(S_POS, 1'b1, 1'b0, '0, 128'hA3);
        check("pre_rst_wr", W'(bus.CB_wr_en), W'(1));
        #1 sys_rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        m_z1 = '0; m_z2 = '0; m_have1 = 0;
        eff_start = cyc;
        @(negedge clk);
        sys_rst = 1'b0;
        flush();
        step(S_POS, 1'b1, 1'b0, '0, 128'hB1);
        flush();
        check("post_rst_first", bus.CB_dina, 128'hB1);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rnd  = {$urandom, $urandom, $urandom, $urandom};
            pick = $urandom_range(0, 9);
            rrd  = (pick != 0);
            if (pick <= 3)      rsel = {3'b100, 2'($urandom_range(0, 3))};
            else if (pick <= 7) rsel = {3'b111, 2'($urandom_range(0, 3))};
            else                rsel = 5'($urandom_range(0, 31));
            if (!rrd) step(S_NL, 1'b0, 1'($urandom), '0, rnd);
            else      step(rsel, 1'b1, 1'($urandom), 10'($urandom_range(0, 3)), rnd);
        end
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tb_douta_map.md
# tb_douta_map

Read-side lane mapper for the temporary buffer (TB) port A. It takes raw TB read data and produces the covariance-buffer write-back word (`CB_dina`) with the inverse lane ordering of the TB write path. In the UPD non-linear phase it also captures the two innovation results for the non-linear unit. It compensates the TB BRAM read latency internally, so all controls are sampled at read-request time.

## Interface
Parameters:
- `X`, 4, number of active RSA lanes used for reversal
- `L`, 4, number of lanes per TB word; `L >= X`, and `L >= 4` for NEW mode
- `RSA_DW`, 32, lane width (signed)
- `SEQ_CNT_DW`, 10, sequence counter width
- `TB_DOUTA_SEL_DW`, 5, width of the select field
- `RD_LAT`, 2, TB BRAM read latency in cycles, range 1..4

Ports:
- `clk`  in  1  system clock
- `sys_rst`  in  1  reset, asynchronous, active-high; one clock domain
- `TB_douta_sel`  in  TB_DOUTA_SEL_DW  bits [4:2] mode: 100 CB write-back, 111 NL_UPD capture, any other value idle; bits [1:0] direction: 00 IDLE, 01 POS, 10 NEG, 11 NEW
- `TB_rd_en`  in  1  TB read issued this cycle
- `l_k_0`  in  1  NEW half select
- `seq_cnt_out`  in  SEQ_CNT_DW  sequence counter at request time
- `TB_douta`  in  L*RSA_DW  TB read data, valid RD_LAT cycles after `TB_rd_en`
- `CB_dina`  out  L*RSA_DW  mapped CB write data
- `CB_wr_en`  out  1  CB write strobe
- `nl_z_1`  out  RSA_DW  first captured NL value
- `nl_z_2`  out  RSA_DW  second captured NL value
- `nl_valid`  out  1  one-cycle pulse: `nl_z_1` and `nl_z_2` form a fresh pair

## Operation
- Control pipeline: `TB_douta_sel`, `l_k_0`, `seq_cnt_out` and `TB_rd_en` pass through RD_LAT registers. The delayed copies (`*_d`) align with `TB_douta`.
- Mapping uses only delayed controls. It applies only when `rd_en_d` = 1; otherwise `CB_dina` <= 0 and `CB_wr_en` <= 0.
- Mode 100, CB write-back, `CB_wr_en` <= 1 except for direction IDLE:
  - POS: `CB_dina` <= `TB_douta`.
  - NEG: lane i <= TB lane X-1-i for i < X; lanes X..L-1 <= 0.
  - NEW, `l_k_0_d` = 1: CB lanes 0,1 <= TB lanes 0,1.
  - NEW, `l_k_0_d` = 0: CB lanes 0,1 <= TB lanes 2,3.
  - NEW, both cases: all other lanes <= 0.
  - IDLE: `CB_dina` <= 0, `CB_wr_en` <= 0.
- Mode 111, NL_UPD: `CB_wr_en` <= 0 and `CB_dina` <= 0. Only TB lane 0 is used, via the capture FSM:
  - NL_IDLE: `seq_d` = 1 → `nl_z_1` <= lane 0, go to NL_HAVE1. `seq_d` = 2 is ignored here (no capture, no pulse).
  - NL_HAVE1: `seq_d` = 2 → `nl_z_2` <= lane 0, `nl_valid` <= 1, go to NL_IDLE.
  - NL_HAVE1: `seq_d` = 1 again → overwrite `nl_z_1`, stay in NL_HAVE1.
  - NL_HAVE1: `sel_d` leaves mode 111 → go to NL_IDLE, no pulse.
- `nl_z_1` and `nl_z_2` hold their values until recaptured.
- Any other mode: outputs 0; FSM returns to NL_IDLE.
- No arithmetic is performed; lanes are copied bit-exact and zero fill is all-zeros.

## Timing
- Reset (asynchronous, immediate): all pipeline stages 0, FSM in NL_IDLE, and `CB_dina`, `CB_wr_en`, `nl_z_1`, `nl_z_2`, `nl_valid` all 0.
- Latency: `TB_rd_en` at cycle t → `CB_wr_en` and `CB_dina` registered at edge t+RD_LAT+1.
- `nl_valid` rises at the same edge at which `nl_z_2` updates, and lasts one cycle.
- Fully pipelined: a new read may be issued every cycle, including back-to-back mode changes. Each output word reflects the controls of its own request.
- Reset mid-burst: in-flight reads are discarded and produce no `CB_wr_en`. The first valid output after reset is RD_LAT+1 cycles after the first post-reset `TB_rd_en`.
- `nl_valid` fires only when seq 1 is followed by seq 2 within one uninterrupted mode-111 run.

## Configuration
- `TB_DOUTA_NEG_EN` defined: the NEG reversal is implemented as described.
- Not defined: NEG is treated like IDLE, giving `CB_dina` = 0 and `CB_wr_en` = 0; the reversal logic is absent.

## Test plan
- POS, RD_LAT=2: `TB_rd_en` at t with lanes {3,2,1,0} = {0x4,0x3,0x2,0x1} → at t+3, `CB_wr_en` = 1 and `CB_dina` equals the same word.
- NEG (macro on): lanes 0..3 = {0x11,0x22,0x33,0x44} → CB lanes 0..3 = {0x44,0x33,0x22,0x11}. Macro off → `CB_wr_en` = 0, `CB_dina` = 0.
- NEW, TB lanes {L0=0xA, L1=0xB, L2=0xC, L3=0xD}: `l_k_0` = 1 → CB {0xA,0xB,0,0}; `l_k_0` = 0 → CB {0xC,0xD,0,0}. Toggle `l_k_0` on back-to-back cycles and check each output matches its own request.
- NL_UPD, lane 0 = 0x100 then 0x200 at seq 1,2 → `nl_z_1` = 0x100, `nl_z_2` = 0x200, `nl_valid` pulses once, `CB_wr_en` stays 0.
  - Seq 2 alone → no pulse.
  - Seq 1 then mode 100 then seq 2 → no pulse.
- Assert `sys_rst` asynchronously with 2 reads in flight → all outputs drop to 0 immediately. Neither in-flight read produces a write after release.
